// File: rtl/jts16_vrom_slots.sv
// Video ROM responder: three single-entry caches (char, scroll, map) sharing one SDRAM read port.
// A client whose address misses is fetched by priority char > scr1 > map1.
module jts16_vrom_slots #(
  parameter logic [21:0] CHAR_OFFSET = 22'h0,
  parameter logic [21:0] MAP_OFFSET  = 22'h0,
  parameter logic [21:0] SCR_OFFSET  = 22'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] char_addr,
  output logic        char_ok,
  output logic [31:0] char_data,
  input  logic [13:0] map1_addr,
  output logic        map1_ok,
  output logic [15:0] map1_data,
  input  logic [15:0] scr1_addr,
  output logic        scr1_ok,
  output logic [31:0] scr1_data,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_rdy,
  input  logic [31:0] sdram_dout
);

  localparam int unsigned AW = 22;
  localparam int unsigned CW = 13;
  localparam int unsigned MW = 14;
  localparam int unsigned SW = 16;
  localparam int unsigned NC = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACK = 2'd1, WAIT_DATA = 2'd2} state_t;
  typedef enum logic [1:0] {CL_CHAR = 2'd0, CL_SCR = 2'd1, CL_MAP = 2'd2} client_t;

  state_t  state, state_nx;
  client_t win_id, pick_id_c;
  logic [SW-1:0] win_addr, pick_addr_c;
  logic [AW-1:0] pick_sdram_c;
  logic [NC-1:0] need_q, need_c;
  logic          start_c, store_c;

  logic [CW-1:0] char_lat_addr;
  logic [31:0]   char_lat_data;
  logic          char_valid;
  logic [MW-1:0] map_lat_addr;
  logic [15:0]   map_lat_data;
  logic          map_valid;
  logic [SW-1:0] scr_lat_addr;
  logic [31:0]   scr_lat_data;
  logic          scr_valid;

  // Hit status follows the live client address in the same cycle
  assign char_ok   = char_valid && (char_addr == char_lat_addr);
  assign map1_ok   = map_valid  && (map1_addr == map_lat_addr);
  assign scr1_ok   = scr_valid  && (scr1_addr == scr_lat_addr);
  assign char_data = char_lat_data;
  assign map1_data = map_lat_data;
  assign scr1_data = scr_lat_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (|need_q) state_nx = WAIT_ACK;
      WAIT_ACK:  if (sdram_ack) state_nx = sdram_rdy ? IDLE : WAIT_DATA;
      WAIT_DATA: if (sdram_rdy) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Arbitration, request/store strobes and the miss detector
  always_comb begin
    start_c      = 1'b0;
    store_c      = 1'b0;
    pick_id_c    = CL_MAP;
    pick_addr_c  = SW'(map1_addr);
    pick_sdram_c = MAP_OFFSET + AW'({map1_addr[13:1], 1'b0});
    if (need_q[0]) begin
      pick_id_c    = CL_CHAR;
      pick_addr_c  = SW'(char_addr);
      pick_sdram_c = CHAR_OFFSET + AW'({char_addr, 1'b0});
    end else if (need_q[1]) begin
      pick_id_c    = CL_SCR;
      pick_addr_c  = scr1_addr;
      pick_sdram_c = SCR_OFFSET + AW'({scr1_addr, 1'b0});
    end
    case (state)
      IDLE:      start_c = |need_q;
      WAIT_ACK:  store_c = sdram_ack & sdram_rdy;
      WAIT_DATA: store_c = sdram_rdy;
      default:   ;
    endcase
    need_c[0] = !char_valid || (char_addr != char_lat_addr);
    need_c[1] = !scr_valid  || (scr1_addr != scr_lat_addr);
    need_c[2] = !map_valid  || (map1_addr != map_lat_addr);
    // The served client's compare is one cycle stale on the store edge
    if (store_c) begin
      case (win_id)
        CL_CHAR: need_c[0] = 1'b0;
        CL_SCR:  need_c[1] = 1'b0;
        default: need_c[2] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      need_q        <= '0;
      win_id        <= CL_CHAR;
      win_addr      <= '0;
      sdram_req     <= 1'b0;
      sdram_addr    <= '0;
      char_lat_addr <= '0;
      char_lat_data <= '0;
      char_valid    <= 1'b0;
      map_lat_addr  <= '0;
      map_lat_data  <= '0;
      map_valid     <= 1'b0;
      scr_lat_addr  <= '0;
      scr_lat_data  <= '0;
      scr_valid     <= 1'b0;
    end else begin
      need_q <= need_c;
      if (start_c) begin
        win_id     <= pick_id_c;
        win_addr   <= pick_addr_c;
        sdram_addr <= pick_sdram_c;
        sdram_req  <= 1'b1;
      end else if (state == WAIT_ACK && sdram_ack) begin
        sdram_req  <= 1'b0;
      end
      if (store_c) begin
        case (win_id)
          CL_CHAR: begin
            char_lat_addr <= CW'(win_addr);
            char_lat_data <= sdram_dout;
            char_valid    <= 1'b1;
          end
          CL_SCR: begin
            scr_lat_addr <= win_addr;
            scr_lat_data <= sdram_dout;
            scr_valid    <= 1'b1;
          end
          default: begin
            map_lat_addr <= MW'(win_addr);
            map_lat_data <= win_addr[0] ? sdram_dout[31:16] : sdram_dout[15:0];
            map_valid    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/jts16_vrom_slots.md
# jts16_vrom_slots

Responder side of the video ROM fetch protocol. The char, tile-map and scroll layer fetchers each hold an address and wait for `*_ok`. This block serves them from SDRAM: it detects which client needs new data, arbitrates among the clients, runs the SDRAM request handshake and returns the data. It sits between the S16 video top and the SDRAM controller, one read port shared by the three video clients.

## Interface
Parameters:
- `CHAR_OFFSET`, 22'h0, SDRAM 16-bit word offset of the char ROM.
- `MAP_OFFSET`, 22'h0, word offset of the tile-map region.
- `SCR_OFFSET`, 22'h0, word offset of the scroll tile ROM.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `char_addr` in 13: char client address, 32-bit granularity.
- `char_ok` out 1: char_data valid for the current char_addr.
- `char_data` out 32: char data.
- `map1_addr` in 14: map client address, 16-bit granularity.
- `map1_ok` out 1: map1_data valid for the current map1_addr.
- `map1_data` out 16: map data.
- `scr1_addr` in 16: scroll client address, 32-bit granularity.
- `scr1_ok` out 1: scr1_data valid for the current scr1_addr.
- `scr1_data` out 32: scroll data.
- `sdram_req` out 1: read request; a level signal.
- `sdram_addr` out 22: word address; stable while `sdram_req`=1.
- `sdram_ack` in 1: one-cycle pulse; request accepted.
- `sdram_rdy` in 1: one-cycle pulse; `sdram_dout` is valid.
- `sdram_dout` in 32: read data; low word is the lower address.

## Operation
- Per client registers: `lat_addr`, `lat_data`, `valid`.
- `*_ok` is combinational: `*_ok = valid && (client addr == lat_addr)`.
  - `*_data` always shows `lat_data`.
  - An address change therefore drops `ok` in the same cycle.
- Need flag per client: `!valid || addr != lat_addr`. Evaluated on registered compare; 1-cycle detect.
- Arbitration uses fixed priority, sampled only in IDLE: char > scr1 > map1.
  - Starvation of map1 is accepted; video fetch patterns leave gaps.
- Address mapping (22-bit arithmetic, carry out discarded):
  - char: `CHAR_OFFSET + {char_addr,1'b0}`
  - scr1: `SCR_OFFSET + {scr1_addr,1'b0}`
  - map1: `MAP_OFFSET + {map1_addr[13:1],1'b0}`
- map1 data: `map1_addr[0]` selects `sdram_dout[31:16]` when 1, `[15:0]` when 0. The selection is captured at request time.
- FSM states: IDLE, WAIT_ACK, WAIT_DATA.
  - IDLE → WAIT_ACK when any need flag is set. On that edge:
    - capture the winner id, its address and the computed `sdram_addr`;
    - assert `sdram_req`.
  - WAIT_ACK → WAIT_DATA on `sdram_ack`; `sdram_req` deasserts on the same edge.
  - WAIT_ACK → IDLE directly when `sdram_ack` and `sdram_rdy` arrive in the same cycle. Data is stored as in WAIT_DATA.
  - WAIT_DATA → IDLE on `sdram_rdy`. On that edge, for the winner:
    - `lat_addr` ← captured address;
    - `lat_data` ← returned data;
    - `valid` ← 1.
- Stale fetch: if the client address changed during the fetch, the data is still stored under the captured address. `ok` stays 0 because of the compare, and a refetch is raised from IDLE.
- `sdram_rdy` or `sdram_ack` seen in IDLE is ignored.
- Other clients' registers are never touched by a fetch.

## Timing
- Reset values, asynchronous on `rst_n`=0:
  - state IDLE;
  - all `valid`=0, `lat_addr`=0, `lat_data`=0;
  - all `*_ok`=0, all `*_data`=0;
  - `sdram_req`=0, `sdram_addr`=0.
- Reset mid-fetch: the fetch is abandoned, no register is written, and a late `sdram_rdy` is ignored.
- Minimum miss latency, from address change at edge N:
  - need registered at N+1;
  - `sdram_req`=1 after N+2;
  - data stored on the `sdram_rdy` edge;
  - `ok`=1 in the following cycle.
- After `sdram_rdy`, one IDLE cycle before the next request. The back-to-back request rate is therefore the SDRAM latency + 2 cycles.
- `sdram_addr` changes only on the IDLE→WAIT_ACK edge.

## Test plan
- Reset, then `char_addr`=13'h0010 with SDRAM model ack at +2 and rdy at +5 returning 32'hDEADBEEF:
  - `sdram_addr` = `CHAR_OFFSET`+22'h20;
  - `char_ok`=1 with `char_data`=32'hDEADBEEF;
  - `char_addr` held: no further request issued.
- All three clients miss simultaneously: request order is char, scr1, map1. Each `ok` rises only after its own `rdy`; the others stay 0 until served.
- `map1_addr`=14'h0003 with returned data 32'h1234_5678:
  - `sdram_addr`=`MAP_OFFSET`+2;
  - `map1_data`=16'h1234;
  - then `map1_addr`=14'h0002 → new fetch (the cache is a single entry keyed on the full address) returning `map1_data`=16'h5678.
- `scr1_addr` changes from 16'h0100 to 16'h0101 while in WAIT_DATA:
  - the old data is stored and `scr1_ok` stays 0;
  - a second fetch at `SCR_OFFSET`+22'h202 follows;
  - `scr1_ok`=1 after it completes.
- Same-cycle `sdram_ack`+`sdram_rdy`: the FSM returns to IDLE and data is stored. A stray `sdram_rdy` in IDLE changes nothing.
- `rst_n` pulsed low during WAIT_DATA, `sdram_rdy` arriving 2 cycles after release:
  - all `ok`=0, `lat_data`=0, `sdram_req`=0;
  - the late `rdy` is ignored;
  - fresh fetches then proceed normally.
